// File: rtl/mc_sched_if.sv
// Bundle between mc_sched, the metric router/MC and the LLR output buffer.
//   i_start, i_mode     : symbol request and APSK mode (environment -> sequencer)
//   i_mc_metric         : registered MC minimum, valid the cycle after o_mc_en
//   o_busy              : sequencer occupied
//   o_mc_en, o_bit_idx,
//   o_hyp, o_chunk      : MC issue strobe and router subset selection
//   o_llr, o_llr_valid,
//   o_llr_idx, o_done   : LLR stream and end-of-symbol pulse
interface mc_sched_if #(
  parameter int unsigned wordlength = 18
) ();

  logic                         i_start;
  logic [1:0]                   i_mode;
  logic signed [wordlength-1:0] i_mc_metric;
  logic                         o_busy;
  logic                         o_mc_en;
  logic [2:0]                   o_bit_idx;
  logic                         o_hyp;
  logic                         o_chunk;
  logic signed [wordlength:0]   o_llr;
  logic                         o_llr_valid;
  logic [2:0]                   o_llr_idx;
  logic                         o_done;

  // Sequencer side
  modport slave (
    input  i_start, i_mode, i_mc_metric,
    output o_busy, o_mc_en, o_bit_idx, o_hyp, o_chunk,
    output o_llr, o_llr_valid, o_llr_idx, o_done
  );

  // Environment side (router/MC model, start source, LLR sink)
  modport master (
    output i_start, i_mode, i_mc_metric,
    input  o_busy, o_mc_en, o_bit_idx, o_hyp, o_chunk,
    input  o_llr, o_llr_valid, o_llr_idx, o_done
  );

endinterface

// File: rtl/mc_sched.sv
// mc_sched: time-shares one registered 32-input min-comparator across all
// bit-LLR computations of a 16/32/64/128-APSK max-log demapper.
// Per symbol, for each label bit (MSB first) it issues hyp0 then hyp1 passes
// (two chunk passes per hypothesis in 128APSK), min-accumulates the returned
// metrics and emits LLR = min(hyp1) - min(hyp0), one bit at a time.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mc_sched_if.slave (start/mode in, MC issue control out,
//                MC metric in, LLR stream out)
module mc_sched #(
  parameter int unsigned wordlength = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  mc_sched_if.slave   bus
);

  localparam int unsigned WL = wordlength;
  localparam int unsigned LW = wordlength + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Issue-side registers (also the registered router controls)
  logic [1:0] mode_q, mode_d;
  logic       busy_q, busy_d;
  logic       mc_en_q, mc_en_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       hyp_q, hyp_d;
  logic       chunk_q, chunk_d;

  // Tags of the issue whose MC result arrives this cycle
  logic       res_vld_q, res_vld_d;
  logic [2:0] res_bit_q, res_bit_d;
  logic       res_hyp_q, res_hyp_d;
  logic       res_chunk_q, res_chunk_d;
  logic       res_hyp_done_q, res_hyp_done_d;
  logic       res_last_q, res_last_d;

  // Accumulators and LLR output registers
  logic signed [WL-1:0] acc_q, acc_d;
  logic signed [WL-1:0] min0_q, min0_d;
  logic signed [LW-1:0] llr_q, llr_d;
  logic                 llr_valid_q, llr_valid_d;
  logic [2:0]           llr_idx_q, llr_idx_d;
  logic                 done_q, done_d;

  // Mode-derived limits of the running symbol
  logic       two_chunk_c;
  logic [2:0] last_bit_c;
  logic       last_issue_c;
  logic signed [WL-1:0] acc_c;

  assign two_chunk_c  = (mode_q == 2'd3);
  assign last_bit_c   = 3'(mode_q) + 3'd3;
  assign last_issue_c = (bit_idx_q == last_bit_c) && hyp_q && (chunk_q == two_chunk_c);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.i_start) state_d = ST_ISSUE;
      ST_ISSUE: if (last_issue_c) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Issue-side outputs: next strobe and chunk -> hyp -> bit counter advance
  always_comb begin
    mode_d    = mode_q;
    mc_en_d   = 1'b0;
    bit_idx_d = bit_idx_q;
    hyp_d     = hyp_q;
    chunk_d   = chunk_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          mode_d    = bus.i_mode;
          mc_en_d   = 1'b1;
          bit_idx_d = 3'd0;
          hyp_d     = 1'b0;
          chunk_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        // On the final issue the selection holds its last value
        if (!last_issue_c) begin
          mc_en_d = 1'b1;
          if (two_chunk_c && !chunk_q) begin
            chunk_d = 1'b1;
          end else begin
            chunk_d = 1'b0;
            if (!hyp_q) begin
              hyp_d = 1'b1;
            end else begin
              hyp_d     = 1'b0;
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Result-side tags: delay the issue selection to line up with the MC output
  always_comb begin
    res_vld_d      = mc_en_q;
    res_bit_d      = bit_idx_q;
    res_hyp_d      = hyp_q;
    res_chunk_d    = chunk_q;
    res_hyp_done_d = mc_en_q && (chunk_q == two_chunk_c);
    res_last_d     = mc_en_q && last_issue_c;
  end

  // Running minimum for the current hypothesis; chunk0 restarts it, ties keep acc
  assign acc_c = !res_chunk_q ? bus.i_mc_metric :
                 ((acc_q <= bus.i_mc_metric) ? acc_q : bus.i_mc_metric);

  // Accumulate, capture hyp0 minimum, form LLR when hyp1 completes
  always_comb begin
    acc_d       = acc_q;
    min0_d      = min0_q;
    llr_d       = llr_q;
    llr_idx_d   = llr_idx_q;
    llr_valid_d = 1'b0;
    done_d      = 1'b0;
    if (res_vld_q) begin
      acc_d = acc_c;
      if (res_hyp_done_q && !res_hyp_q) begin
        min0_d = acc_c;
      end
      if (res_hyp_done_q && res_hyp_q) begin
        // One guard bit makes the difference exact for any pair of metrics
        llr_d       = {acc_c[WL-1], acc_c} - {min0_q[WL-1], min0_q};
        llr_idx_d   = res_bit_q;
        llr_valid_d = 1'b1;
      end
      done_d = res_last_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= 2'd0;
      busy_q         <= 1'b0;
      mc_en_q        <= 1'b0;
      bit_idx_q      <= 3'd0;
      hyp_q          <= 1'b0;
      chunk_q        <= 1'b0;
      res_vld_q      <= 1'b0;
      res_bit_q      <= 3'd0;
      res_hyp_q      <= 1'b0;
      res_chunk_q    <= 1'b0;
      res_hyp_done_q <= 1'b0;
      res_last_q     <= 1'b0;
      acc_q          <= '0;
      min0_q         <= '0;
      llr_q          <= '0;
      llr_valid_q    <= 1'b0;
      llr_idx_q      <= 3'd0;
      done_q         <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      busy_q         <= busy_d;
      mc_en_q        <= mc_en_d;
      bit_idx_q      <= bit_idx_d;
      hyp_q          <= hyp_d;
      chunk_q        <= chunk_d;
      res_vld_q      <= res_vld_d;
      res_bit_q      <= res_bit_d;
      res_hyp_q      <= res_hyp_d;
      res_chunk_q    <= res_chunk_d;
      res_hyp_done_q <= res_hyp_done_d;
      res_last_q     <= res_last_d;
      acc_q          <= acc_d;
      min0_q         <= min0_d;
      llr_q          <= llr_d;
      llr_valid_q    <= llr_valid_d;
      llr_idx_q      <= llr_idx_d;
      done_q         <= done_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_mc_en     = mc_en_q;
  assign bus.o_bit_idx   = bit_idx_q;
  assign bus.o_hyp       = hyp_q;
  assign bus.o_chunk     = chunk_q;
  assign bus.o_llr       = llr_q;
  assign bus.o_llr_valid = llr_valid_q;
  assign bus.o_llr_idx   = llr_idx_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_mc_sched.sv
// Testbench for mc_sched: router/MC model driven from a metric table, a
// per-symbol reference model that queues expected issues and LLRs, and a
// monitor that checks issue order, busy, LLR values/timing and done.
module tb_mc_sched;

  localparam int WL = 18;

  typedef struct { int llr; int idx; int cyc; bit done; } llr_t;
  typedef struct { int b; int h; int c; int cyc; } iss_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  mc_sched_if #(.wordlength(WL)) bus ();

  mc_sched #(.wordlength(WL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Metric the router/MC returns for (bit, hyp, chunk) of the current symbol
  logic signed [WL-1:0] tbl [0:6][0:1][0:1];

  llr_t exp_llr [$];
  iss_t exp_iss [$];

  bit sym_active;
  int sym_start;
  int sym_n;

  bit                   pend_vld;
  logic signed [WL-1:0] pend_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + MC model, sampled 2 time units after the active edge
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      pend_vld = 1'b0;
      bus.i_mc_metric = '0;
      n_tests++;
      if ({bus.o_busy, bus.o_mc_en, bus.o_llr_valid, bus.o_done, bus.o_hyp, bus.o_chunk} != 6'd0 ||
          bus.o_llr != '0 || bus.o_llr_idx != 3'd0 || bus.o_bit_idx != 3'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d busy=%0b mc_en=%0b vld=%0b done=%0b llr=%0d idx=%0d bit=%0d hyp=%0b chunk=%0b, required all 0",
                 cyc, bus.o_busy, bus.o_mc_en, bus.o_llr_valid, bus.o_done, bus.o_llr,
                 bus.o_llr_idx, bus.o_bit_idx, bus.o_hyp, bus.o_chunk);
      end
    end else begin
      // MC result for last cycle's issue; junk otherwise
      bus.i_mc_metric = pend_vld ? pend_val : WL'($urandom);
      pend_vld = bus.o_mc_en;
      if (bus.o_mc_en) begin
        pend_val = (bus.o_bit_idx <= 3'd6) ? tbl[bus.o_bit_idx][bus.o_hyp][bus.o_chunk] : '0;
        n_tests++;
        if (exp_iss.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue cyc=%0d got (%0d,%0d,%0d), required no issue",
                   cyc, bus.o_bit_idx, bus.o_hyp, bus.o_chunk);
        end else begin
          iss_t e;
          e = exp_iss.pop_front();
          if (int'(bus.o_bit_idx) != e.b || int'(bus.o_hyp) != e.h ||
              int'(bus.o_chunk) != e.c || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL issue_order got (%0d,%0d,%0d)@%0d, required (%0d,%0d,%0d)@%0d",
                     bus.o_bit_idx, bus.o_hyp, bus.o_chunk, cyc, e.b, e.h, e.c, e.cyc);
          end
        end
      end

      begin
        bit exp_busy;
        exp_busy = sym_active && (cyc >= sym_start + 1) && (cyc <= sym_start + sym_n + 1);
        n_tests++;
        if (bus.o_busy != exp_busy) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got %0b, required %0b", cyc, bus.o_busy, exp_busy);
        end
      end

      if (bus.o_llr_valid || bus.o_done) begin
        n_tests++;
        if (exp_llr.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_llr cyc=%0d vld=%0b llr=%0d idx=%0d done=%0b, required none",
                   cyc, bus.o_llr_valid, bus.o_llr, bus.o_llr_idx, bus.o_done);
        end else begin
          llr_t e;
          e = exp_llr.pop_front();
          if (!bus.o_llr_valid || int'(bus.o_llr) != e.llr || int'(bus.o_llr_idx) != e.idx ||
              cyc != e.cyc || bus.o_done != e.done) begin
            n_fail++;
            $display("FAIL llr got vld=%0b llr=%0d idx=%0d done=%0b @%0d, required llr=%0d idx=%0d done=%0b @%0d",
                     bus.o_llr_valid, bus.o_llr, bus.o_llr_idx, bus.o_done, cyc,
                     e.llr, e.idx, e.done, e.cyc);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse i_start for one cycle; the model decides acceptance and queues expectations
  task automatic issue_start(input int mode);
    bit acc;
    acc = !(sym_active && (cyc <= sym_start + sym_n + 1));
    bus.i_start = 1'b1;
    bus.i_mode  = 2'(mode);
    if (acc) begin
      int nb, nc, k, m0, m1;
      nb = mode + 4;
      nc = (mode == 3) ? 2 : 1;
      sym_active = 1'b1;
      sym_start  = cyc;
      sym_n      = 2 * nb * nc;
      k = 0;
      for (int b = 0; b < nb; b++) begin
        for (int h = 0; h < 2; h++) begin
          for (int c = 0; c < nc; c++) begin
            exp_iss.push_back('{b, h, c, cyc + 1 + k});
            k++;
          end
        end
        m0 = int'(tbl[b][0][0]);
        m1 = int'(tbl[b][1][0]);
        if (nc == 2) begin
          if (int'(tbl[b][0][1]) < m0) m0 = int'(tbl[b][0][1]);
          if (int'(tbl[b][1][1]) < m1) m1 = int'(tbl[b][1][1]);
        end
        exp_llr.push_back('{m1 - m0, b, cyc + 2 + 2 * nc * (b + 1), (b == nb - 1)});
      end
    end
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_mode  = 2'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_llr.size() != 0 || exp_iss.size() != 0) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_tests++;
    if (exp_llr.size() != 0 || exp_iss.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending llr=%0d issues=%0d, required 0 and 0",
               exp_llr.size(), exp_iss.size());
      exp_llr.delete();
      exp_iss.delete();
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sym_active = 1'b0;
    exp_llr.delete();
    exp_iss.delete();
    wait_cyc(n);
    rst_n = 1'b1;
  endtask

  task automatic fill_const(input int h0, input int h1);
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 2; c++) begin
        tbl[b][0][c] = WL'(h0);
        tbl[b][1][c] = WL'(h1);
      end
    end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 7; b++)
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < 2; c++)
          tbl[b][h][c] = WL'($urandom);
    // Occasional ties and extremes
    if ($urandom_range(0, 3) == 0) tbl[1][0][1] = tbl[1][0][0];
    if ($urandom_range(0, 3) == 0) tbl[2][1][0] = WL'(131071);
    if ($urandom_range(0, 3) == 0) tbl[2][0][0] = WL'(-131072);
  endtask

  initial begin
    int s;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    sym_active = 1'b0;
    sym_start  = 0;
    sym_n      = 0;
    pend_vld   = 1'b0;
    pend_val   = '0;
    rst_n      = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_mode      = 2'd0;
    bus.i_mc_metric = '0;
    fill_const(0, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);

    // Mode 0: 40 - 100 on every bit, LLRs in cycles 4,6,8,10
    fill_const(100, 40);
    issue_start(0);
    wait_idle();

    // Mode 3 with bit 2 directed: min(90,300) - min(500,120) = -30
    fill_rand();
    tbl[2][0][0] = WL'(500);
    tbl[2][0][1] = WL'(120);
    tbl[2][1][0] = WL'(90);
    tbl[2][1][1] = WL'(300);
    issue_start(3);
    wait_idle();

    // Extremes: +262143 and -262143 without wrap
    fill_const(-131072, 131071);
    issue_start(1);
    wait_idle();
    fill_const(131071, -131072);
    issue_start(2);
    wait_idle();

    // Starts at 0, 5, 12 in mode 1: middle ignored, last back-to-back
    fill_rand();
    wait_cyc(1);
    s = cyc;
    issue_start(1);
    wait_until(s + 5);
    issue_start(2);
    wait_until(s + 12);
    issue_start(1);
    wait_idle();

    // Mode 2 aborted by reset in cycle 6 for two cycles, then a clean symbol
    fill_rand();
    s = cyc;
    issue_start(2);
    wait_until(s + 6);
    do_reset(2);
    wait_cyc(3);
    fill_rand();
    issue_start(2);
    wait_idle();

    // Randomized symbols, back-to-back or with gaps, with ignored mid-symbol pulses
    for (int i = 0; i < 24; i++) begin
      int mode, n;
      mode = int'($urandom_range(0, 3));
      n = 2 * (mode + 4) * ((mode == 3) ? 2 : 1);
      fill_rand();
      s = cyc;
      issue_start(mode);
      if ($urandom_range(0, 2) == 0) begin
        wait_until(s + 1 + int'($urandom_range(0, n - 1)));
        issue_start(int'($urandom_range(0, 3)));
      end
      wait_until(s + n + 2 + int'($urandom_range(0, 2)) * int'($urandom_range(0, 1)));
    end
    wait_idle();
    wait_cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_sched.md
# mc_sched

Sequencer that time-shares one 32-input registered minimum-comparator (MC) across all bit-LLR computations of a multi-mode APSK exhaustive demapper. Per symbol it issues, for every label bit and both hypotheses, one or two MC passes, min-accumulates their results, and emits max-log LLRs (min over hypothesis-1 metrics minus min over hypothesis-0 metrics) one bit at a time. It sits between the metric router, which presents the 32 metrics selected by this block's control outputs, and the LLR output buffer.

## Interface
- wordlength, default 18: metric width (signed), must match the MC.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle request to demap one symbol; accepted only when o_busy=0.
- i_mode  in  2  0=16APSK (4 bits), 1=32APSK (5), 2=64APSK (6), 3=128APSK (7); latched at accepted start.
- o_busy  out  1  high from the cycle after start acceptance until the sequence ends.
- o_mc_en  out  1  issue strobe to MC en and the metric router.
- o_bit_idx  out  3  label bit under evaluation (0 = MSB).
- o_hyp  out  1  hypothesis: the router selects points whose bit o_bit_idx equals o_hyp.
- o_chunk  out  1  subset half (mode 3 only, 64-point subsets); 0 in other modes.
- i_mc_metric  in  wordlength  MC output, signed; valid in the cycle after each o_mc_en.
- o_llr  out  wordlength+1  signed LLR.
- o_llr_valid  out  1  one-cycle strobe per LLR.
- o_llr_idx  out  3  bit index of o_llr.
- o_done  out  1  one-cycle pulse coincident with the last o_llr_valid of the symbol.

## Operation
- Bits per mode B = 4/5/6/7; chunks C = 1 (modes 0-2) or 2 (mode 3); issues N = 2·B·C = 8/10/12/28.
- Issue order per bit b = 0..B-1: (hyp0, chunk0), [(hyp0, chunk1)], (hyp1, chunk0), [(hyp1, chunk1)]. Bracketed entries apply to mode 3 only. One issue per cycle with no bubbles.
- Unused MC inputs (subsets smaller than 32) are padded by the router with 2^(wordlength-1)-1. This block does not handle padding.
- FSM states:
  - IDLE: accepts start, latches mode; next ISSUE.
  - ISSUE: asserts o_mc_en, advances chunk → hyp → bit counters; after issue N-1, next DRAIN.
  - DRAIN: one cycle for the final MC result; next IDLE.
- Accumulator, on each returned result:
  - chunk0: acc ← i_mc_metric.
  - chunk1: acc ← min(acc, i_mc_metric), using the ≤ rule.
  - When hyp0 is complete, min0 ← acc.
  - When hyp1 is complete, register o_llr = sign-extended(acc) − sign-extended(min0), computed at wordlength+1 bits. This cannot overflow, and no saturation is applied.
- o_bit_idx, o_hyp and o_chunk hold their last values when o_mc_en=0. They are don't-care to the router.
- i_start while o_busy=1 is ignored. i_mode changes mid-symbol have no effect.
- o_busy = (state != IDLE).

## Timing
- Define cycle 0 as the cycle in which i_start=1 is sampled while in IDLE.
- Issue k (k = 0..N-1) has o_mc_en=1 in cycle 1+k; its MC result is in cycle 2+k.
- Each LLR has o_llr_valid in cycle 3+k_last(b), where k_last(b) = 2C(b+1) − 1 is the bit's final issue.
- o_done and the last o_llr_valid occur in cycle N+2: 10/12/14/30 for modes 0/1/2/3.
- o_busy is 1 in cycles 1..N+1 and 0 in cycle N+2. A new i_start in cycle N+2 is accepted, so back-to-back symbols take N+2 cycles each.
- Reset values: o_busy, o_mc_en, o_llr_valid, o_done = 0; o_llr, o_llr_idx, o_bit_idx, o_hyp, o_chunk = 0; state IDLE; accumulators 0.
- Reset mid-operation aborts immediately: no o_done, no partial LLR. After rst_n deassertion the block is in IDLE.
- Downstream has no backpressure; o_llr is held only for its valid cycle.

## Test plan
- Mode 0, MC model returns 100 for hyp0 and 40 for hyp1 on every bit → four LLRs of −60, idx 0..3, in cycles 4,6,8,10; o_done in cycle 10.
- Mode 3, bit 2: hyp0 chunk results 500 then 120, hyp1 results 90 then 300 → LLR(2) = 90 − 120 = −30; 28 issues; o_done in cycle 30.
- Extremes, wordlength 18: hyp1 = 131071, hyp0 = −131072 → o_llr = +262143. Swapped → −262143. No wrap.
- i_start pulsed in cycles 0, 5 and 12 in mode 1 → second pulse ignored, third accepted (cycle N+2 = 12), 10 LLRs per symbol, o_done in cycles 12 and 24.
- Mode 2 start, rst_n low in cycle 6 for 2 cycles → all outputs 0, no o_done. A start after release produces a full, correct 6-LLR sequence.
- Order check, mode 3: log (o_bit_idx, o_hyp, o_chunk) over cycles 1..28 → exactly (b,0,0),(b,0,1),(b,1,0),(b,1,1) for b = 0..6.
